snapshot_capture_ctrl: RTL

Sequences the camera-to-SDRAM frame-buffer write path between live streaming and single-frame snapshot capture. It gates the pixel write strobe into the SDRAM write FIFOs and issues write-pointer load pulses only during vertical blanking. It also verifies that a captured frame holds exactly the expected pixel count, retrying or flagging an error otherwise. It sits in the pixel-clock domain between the RAW-to-RGB stage and the SDRAM controller write ports.

---
 rtl/snapshot_capture_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/snapshot_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : snapshot_capture_ctrl
// Description : Live-stream / single-frame snapshot sequencer for the
//               camera-to-SDRAM write path, with pixel-count verification.
// Revision    : 1.0 - initial release
// ============================================================================
module snapshot_capture_ctrl #(
   parameter int FRAME_PIXELS = 307200,
   parameter int CNT_W        = 20,
   parameter int TIMEOUT      = 25000000,
   parameter int TO_W         = 25,
   parameter int MAX_RETRY    = 2
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iSNAP,
   input  logic             iLIVE,
   input  logic             iFVAL,
   input  logic             iDVAL,
   output logic             oWR_EN,
   output logic             oWR_LOAD,
   output logic [2:0]       oSTATE,
   output logic             oBUSY,
   output logic             oDONE,
   output logic             oERR,
   output logic [CNT_W-1:0] oPix_Cnt,
   output logic [15:0]      oSnap_Cnt
);

   localparam logic [2:0] c_LIVE     = 3'd0;
   localparam logic [2:0] c_SYNC     = 3'd1;
   localparam logic [2:0] c_LOAD     = 3'd2;
   localparam logic [2:0] c_WAIT_SOF = 3'd3;
   localparam logic [2:0] c_CAPTURE  = 3'd4;
   localparam logic [2:0] c_CHECK    = 3'd5;
   localparam logic [2:0] c_FROZEN   = 3'd6;
   localparam logic [2:0] c_RESUME   = 3'd7;

   localparam int              c_RW      = $clog2(MAX_RETRY + 2);
   localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] c_FRAME  = CNT_W'(FRAME_PIXELS);
   localparam logic [c_RW-1:0] c_RETRIES = c_RW'(MAX_RETRY);

   logic [2:0]       r_state;
   logic [2:0]       w_next;
   logic             r_fval_d;
   logic [TO_W-1:0]  r_tcnt;
   logic [CNT_W-1:0] r_pix;
   logic [c_RW-1:0]  r_retry;
   logic             r_wr_load;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic [CNT_W-1:0] r_pix_out;
   logic [15:0]      r_snap_cnt;

   logic w_sof, w_eof, w_to_en, w_expired, w_good, w_can_retry;
   logic w_wr_gate, w_count, w_snap_req, w_fail;

   assign w_sof       = iFVAL & ~r_fval_d;
   assign w_eof       = ~iFVAL & r_fval_d;
   assign w_to_en     = (r_state == c_SYNC) | (r_state == c_WAIT_SOF) |
                        (r_state == c_CAPTURE) | (r_state == c_RESUME);
   assign w_expired   = w_to_en & (r_tcnt == c_TO_LAST);
   assign w_good      = (r_pix == c_FRAME);
   assign w_can_retry = (r_retry < c_RETRIES);

   // State register
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) r_state <= c_RESUME;
      else      r_state <= w_next;
   end

   // Next-state logic: an abort request outranks a timeout in the abortable states
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_LIVE:     if (iSNAP) w_next = c_SYNC;
         c_SYNC: begin
            if (iLIVE)          w_next = c_RESUME;
            else if (w_expired) w_next = c_FROZEN;
            else if (!iFVAL)    w_next = c_LOAD;
         end
         c_LOAD:     w_next = iLIVE ? c_RESUME : c_WAIT_SOF;
         c_WAIT_SOF: begin
            if (iLIVE)          w_next = c_RESUME;
            else if (w_expired) w_next = c_FROZEN;
            else if (w_sof)     w_next = c_CAPTURE;
         end
         c_CAPTURE: begin
            if (iLIVE)          w_next = c_RESUME;
            else if (w_expired) w_next = c_FROZEN;
            else if (w_eof)     w_next = c_CHECK;
         end
         c_CHECK: begin
            if (iLIVE)            w_next = c_RESUME;
            else if (w_good)      w_next = c_FROZEN;
            else if (w_can_retry) w_next = c_LOAD;
            else                  w_next = c_FROZEN;
         end
         c_FROZEN: begin
            if (iSNAP)      w_next = c_SYNC;
            else if (iLIVE) w_next = c_RESUME;
         end
         default: begin
            if (w_expired)   w_next = c_FROZEN;
            else if (!iFVAL) w_next = c_LIVE;
         end
      endcase
   end

   // Output decode; the SOF pixel is written from WAIT_SOF so the frame is complete
   always_comb begin
      w_wr_gate  = 1'b0;
      w_snap_req = 1'b0;
      case (r_state)
         c_LIVE:     begin w_wr_gate = 1'b1; w_snap_req = iSNAP; end
         c_WAIT_SOF: w_wr_gate = (w_next == c_CAPTURE);
         c_CAPTURE:  w_wr_gate = 1'b1;
         c_FROZEN:   w_snap_req = iSNAP;
         default:    w_wr_gate = 1'b0;
      endcase
      w_count = w_wr_gate & iDVAL & (r_state != c_LIVE);
      w_fail  = (w_expired & (w_next == c_FROZEN)) |
                ((r_state == c_CHECK) & (w_next == c_FROZEN) & ~w_good);
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_fval_d   <= 1'b0;
         r_tcnt     <= '0;
         r_pix      <= '0;
         r_retry    <= '0;
         r_wr_load  <= 1'b0;
         r_busy     <= 1'b1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_pix_out  <= '0;
         r_snap_cnt <= '0;
      end else begin
         r_fval_d <= iFVAL;

         if (w_next != r_state) r_tcnt <= '0;
         else if (w_to_en)      r_tcnt <= r_tcnt + 1'b1;

         if (r_state == c_LOAD)
            r_pix <= '0;
         else if (w_count && (r_pix != {CNT_W{1'b1}}))
            r_pix <= r_pix + 1'b1;

         if (w_snap_req)
            r_retry <= '0;
         else if ((r_state == c_CHECK) && (w_next == c_LOAD))
            r_retry <= r_retry + 1'b1;

         if (w_snap_req)  r_err <= 1'b0;
         else if (w_fail) r_err <= 1'b1;

         r_wr_load <= (w_next == c_LOAD) | ((r_state == c_RESUME) & (w_next == c_LIVE));
         r_busy    <= (w_next != c_LIVE) & (w_next != c_FROZEN);
         r_done    <= (w_next == c_FROZEN) &
                      ((r_state == c_FROZEN) ? r_done : ((r_state == c_CHECK) & w_good));

         if (r_state == c_CHECK) r_pix_out <= r_pix;
         if ((r_state == c_CHECK) && (w_next == c_FROZEN) && w_good)
            r_snap_cnt <= r_snap_cnt + 16'd1;
      end
   end

   assign oWR_EN    = iDVAL & w_wr_gate;
   assign oWR_LOAD  = r_wr_load;
   assign oSTATE    = r_state;
   assign oBUSY     = r_busy;
   assign oDONE     = r_done;
   assign oERR      = r_err;
   assign oPix_Cnt  = r_pix_out;
   assign oSnap_Cnt = r_snap_cnt;

endmodule
`default_nettype wire
